// File: rtl/ahmes_control_unit.sv
// ahmes_control_unit
// Instruction sequencer for the Ahmes CPU. Fetches and decodes instructions
// from an 8-bit memory, holds PC/IR/AC and the N/Z/V/C/B flags, drives the
// external ALU and latches its result, and resolves conditional jumps.
//
// Ports
//   clk, rst            clock (rising edge) and asynchronous active-high reset
//   mem_req/mem_we      request strobe (held until mem_ack) and write select
//   mem_addr/mem_wdata  address and write data, stable while mem_req is high
//   mem_rdata/mem_ack   read data and one-cycle completion pulse
//   alu_op              ALU opcode, non-zero only in the EXEC cycle
//   alu_a/alu_b/alu_cin operands (AC, MDR) and carry-in (flag C)
//   alu_result          ALU result
//   alu_n/z/c/v         ALU flags; the borrow flag arrives on alu_borrow
//                       because alu_b is already the operand-B output
//   ac, pc, flags       architectural state, flags = {N,Z,V,C,B}
//   halted              high while the sequencer sits in HALT
module ahmes_control_unit #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  output logic       mem_req,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  input  logic       mem_ack,
  output logic [3:0] alu_op,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic       alu_cin,
  input  logic [7:0] alu_result,
  input  logic       alu_n,
  input  logic       alu_z,
  input  logic       alu_c,
  input  logic       alu_borrow,
  input  logic       alu_v,
  output logic [7:0] ac,
  output logic [7:0] pc,
  output logic [4:0] flags,
  output logic       halted
);

  // Instruction opcodes (IR[7:4])
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_STA = 4'h1;
  localparam logic [3:0] OP_LDA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_NOT = 4'h6;
  localparam logic [3:0] OP_SUB = 4'h7;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JN  = 4'h9;
  localparam logic [3:0] OP_JZ  = 4'hA;
  localparam logic [3:0] OP_JC  = 4'hB;
  localparam logic [3:0] OP_SHF = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // ALU opcodes
  localparam logic [3:0] ALU_IDLE = 4'd0;
  localparam logic [3:0] ALU_ADIC = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_OU   = 4'd3;
  localparam logic [3:0] ALU_E    = 4'd4;
  localparam logic [3:0] ALU_NAO  = 4'd5;
  localparam logic [3:0] ALU_DLE  = 4'd7;
  localparam logic [3:0] ALU_DLD  = 4'd8;
  localparam logic [3:0] ALU_DAE  = 4'd9;
  localparam logic [3:0] ALU_DAD  = 4'd10;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_OPADDR = 3'd2,
    ST_OPDATA = 3'd3,
    ST_EXEC   = 3'd4,
    ST_STORE  = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  // Opcodes that carry an address byte after the opcode byte.
  function automatic logic is_two_byte(input logic [3:0] opc);
    logic r;
    r = 1'b0;
    case (opc)
      OP_STA, OP_LDA, OP_ADD, OP_OR, OP_AND, OP_SUB,
      OP_JMP, OP_JN, OP_JZ, OP_JC: r = 1'b1;
      default:                     r = 1'b0;
    endcase
    return r;
  endfunction

  // Jump condition; non-jump opcodes and undefined IR[3:2] codes are not taken.
  function automatic logic jump_taken(input logic [7:0] ir, input logic [4:0] f);
    logic r;
    logic fn, fz, fv, fc, fb;
    {fn, fz, fv, fc, fb} = f;
    r = 1'b0;
    case (ir[7:4])
      OP_JMP: r = 1'b1;
      OP_JN: begin
        case (ir[3:2])
          2'b00:   r = fn;
          2'b01:   r = ~fn;
          2'b10:   r = fv;
          2'b11:   r = ~fv;
          default: r = 1'b0;
        endcase
      end
      OP_JZ: begin
        case (ir[3:2])
          2'b00:   r = fz;
          2'b01:   r = ~fz;
          default: r = 1'b0;
        endcase
      end
      OP_JC: begin
        case (ir[3:2])
          2'b00:   r = fc;
          2'b01:   r = ~fc;
          2'b10:   r = fb;
          2'b11:   r = ~fb;
          default: r = 1'b0;
        endcase
      end
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // ALU opcode presented during EXEC; LDA and NOP leave the ALU idle.
  function automatic logic [3:0] alu_op_for(input logic [7:0] ir);
    logic [3:0] r;
    r = ALU_IDLE;
    case (ir[7:4])
      OP_ADD: r = ALU_ADIC;
      OP_SUB: r = ALU_SUB;
      OP_OR:  r = ALU_OU;
      OP_AND: r = ALU_E;
      OP_NOT: r = ALU_NAO;
      OP_SHF: begin
        case (ir[1:0])
          2'b00:   r = ALU_DAD;
          2'b01:   r = ALU_DAE;
          2'b10:   r = ALU_DLD;
          2'b11:   r = ALU_DLE;
          default: r = ALU_IDLE;
        endcase
      end
      default: r = ALU_IDLE;
    endcase
    return r;
  endfunction

  state_t     state_r;
  logic [7:0] pc_r;
  logic [7:0] ir_r;
  logic [7:0] ac_r;
  logic [7:0] addr_r;
  logic [7:0] mdr_r;
  logic [4:0] flags_r;
  logic       halted_r;
  logic       mem_req_r;
  logic       mem_we_r;
  logic [7:0] mem_addr_r;
  logic [7:0] mem_wdata_r;
  logic [3:0] alu_op_r;

  assign mem_req   = mem_req_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign alu_op    = alu_op_r;
  assign alu_a     = ac_r;
  assign alu_b     = mdr_r;
  assign alu_cin   = flags_r[1];
  assign ac        = ac_r;
  assign pc        = pc_r;
  assign flags     = flags_r;
  assign halted    = halted_r;

  // Sequencer: every memory state first raises a request (one cycle after
  // entry) and then waits for mem_ack; an ack with no request pending is
  // ignored because completion is only recognised while mem_req_r is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_FETCH;
      pc_r        <= RESET_PC;
      ir_r        <= 8'h00;
      ac_r        <= 8'h00;
      addr_r      <= 8'h00;
      mdr_r       <= 8'h00;
      flags_r     <= 5'b01000;
      halted_r    <= 1'b0;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= 8'h00;
      mem_wdata_r <= 8'h00;
      alu_op_r    <= ALU_IDLE;
    end else begin
      case (state_r)
        ST_FETCH: begin
          if (!mem_req_r) begin
            mem_req_r   <= 1'b1;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= pc_r;
            mem_wdata_r <= ac_r;
          end else if (mem_ack) begin
            mem_req_r <= 1'b0;
            ir_r      <= mem_rdata;
            pc_r      <= pc_r + 8'd1;
            state_r   <= ST_DECODE;
          end
        end

        ST_DECODE: begin
          if (ir_r[7:4] == OP_HLT) begin
            halted_r <= 1'b1;
            state_r  <= ST_HALT;
          end else if (is_two_byte(ir_r[7:4])) begin
            state_r <= ST_OPADDR;
          end else begin
            // NOP, NOT, shifts and the unassigned codes C/D run as one-byte ops
            alu_op_r <= alu_op_for(ir_r);
            state_r  <= ST_EXEC;
          end
        end

        ST_OPADDR: begin
          if (!mem_req_r) begin
            mem_req_r   <= 1'b1;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= pc_r;
            mem_wdata_r <= ac_r;
          end else if (mem_ack) begin
            mem_req_r <= 1'b0;
            addr_r    <= mem_rdata;
            pc_r      <= jump_taken(ir_r, flags_r) ? mem_rdata : (pc_r + 8'd1);
            case (ir_r[7:4])
              OP_STA:                     state_r <= ST_STORE;
              OP_JMP, OP_JN, OP_JZ, OP_JC: state_r <= ST_FETCH;
              default:                    state_r <= ST_OPDATA;
            endcase
          end
        end

        ST_OPDATA: begin
          if (!mem_req_r) begin
            mem_req_r   <= 1'b1;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= addr_r;
            mem_wdata_r <= ac_r;
          end else if (mem_ack) begin
            mem_req_r <= 1'b0;
            mdr_r     <= mem_rdata;
            alu_op_r  <= alu_op_for(ir_r);
            state_r   <= ST_EXEC;
          end
        end

        ST_EXEC: begin
          // Flag bits: [4]=N [3]=Z [2]=V [1]=C [0]=B; untouched bits hold.
          case (ir_r[7:4])
            OP_LDA: begin
              ac_r       <= mdr_r;
              flags_r[4] <= mdr_r[7];
              flags_r[3] <= (mdr_r == 8'h00);
            end
            OP_ADD: begin
              ac_r         <= alu_result;
              flags_r[4:1] <= {alu_n, alu_z, alu_v, alu_c};
            end
            OP_SUB: begin
              ac_r       <= alu_result;
              flags_r[4] <= alu_n;
              flags_r[3] <= alu_z;
              flags_r[2] <= alu_v;
              flags_r[0] <= alu_borrow;
            end
            OP_OR, OP_AND, OP_NOT: begin
              ac_r         <= alu_result;
              flags_r[4:3] <= {alu_n, alu_z};
            end
            OP_SHF: begin
              ac_r         <= alu_result;
              flags_r[4:3] <= {alu_n, alu_z};
              flags_r[1]   <= alu_c;
            end
            default: begin
              ac_r <= ac_r;
            end
          endcase
          alu_op_r <= ALU_IDLE;
          state_r  <= ST_FETCH;
        end

        ST_STORE: begin
          if (!mem_req_r) begin
            mem_req_r   <= 1'b1;
            mem_we_r    <= 1'b1;
            mem_addr_r  <= addr_r;
            mem_wdata_r <= ac_r;
          end else if (mem_ack) begin
            mem_req_r <= 1'b0;
            mem_we_r  <= 1'b0;
            state_r   <= ST_FETCH;
          end
        end

        ST_HALT: begin
          state_r <= ST_HALT;
        end

        default: begin
          mem_req_r <= 1'b0;
          alu_op_r  <= ALU_IDLE;
          state_r   <= ST_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahmes_control_unit.sv
// Testbench for ahmes_control_unit: models the memory (with per-access wait
// states) and the ALU, runs a directed program, and scoreboards every memory
// transaction and every ALU opcode against hand-computed expectations.
module tb_ahmes_control_unit;

  logic       clk;
  logic       rst;
  logic       mem_req;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       mem_ack;
  logic [3:0] alu_op;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic       alu_cin;
  logic [7:0] alu_result;
  logic       alu_n;
  logic       alu_z;
  logic       alu_c;
  logic       alu_borrow;
  logic       alu_v;
  logic [7:0] ac;
  logic [7:0] pc;
  logic [4:0] flags;
  logic       halted;

  ahmes_control_unit #(.RESET_PC(8'h10)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_result(alu_result), .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c),
    .alu_borrow(alu_borrow), .alu_v(alu_v),
    .ac(ac), .pc(pc), .flags(flags), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int n_writes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ALU reference model
  logic [8:0] sum9;
  always_comb begin
    sum9       = 9'd0;
    alu_result = 8'h00;
    alu_c      = 1'b0;
    alu_v      = 1'b0;
    alu_borrow = 1'b0;
    case (alu_op)
      4'd1: begin
        sum9       = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
        alu_result = sum9[7:0];
        alu_c      = sum9[8];
        alu_v      = (alu_a[7] == alu_b[7]) && (sum9[7] != alu_a[7]);
      end
      4'd2: begin
        alu_result = alu_a - alu_b;
        alu_borrow = (alu_a < alu_b);
        alu_c      = ~(alu_a < alu_b);
        alu_v      = (alu_a[7] != alu_b[7]) && (alu_result[7] != alu_a[7]);
      end
      4'd3:  alu_result = alu_a | alu_b;
      4'd4:  alu_result = alu_a & alu_b;
      4'd5:  alu_result = ~alu_a;
      4'd6:  alu_result = alu_a ^ alu_b;
      4'd7:  begin alu_result = {alu_a[6:0], alu_cin}; alu_c = alu_a[7]; end
      4'd8:  begin alu_result = {alu_cin, alu_a[7:1]}; alu_c = alu_a[0]; end
      4'd9:  begin alu_result = {alu_a[6:0], 1'b0};    alu_c = alu_a[7]; end
      4'd10: begin alu_result = {1'b0, alu_a[7:1]};    alu_c = alu_a[0]; end
      default: alu_result = 8'h00;
    endcase
    alu_n = alu_result[7];
    alu_z = (alu_result == 8'h00);
  end

  // Memory model: reads wait addr[1:0] cycles, writes wait 3 cycles.
  logic [7:0] mem [0:255];
  int wait_cnt = 0;
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 8'hA5;
    forever begin
      @(posedge clk);
      #1;
      if (mem_ack) begin
        mem_ack   = 1'b0;
        mem_rdata = 8'hA5;
      end else if (mem_req && !rst) begin
        if (wait_cnt < (mem_we ? 3 : int'(mem_addr[1:0]))) begin
          wait_cnt++;
        end else begin
          wait_cnt = 0;
          mem_ack  = 1'b1;
          if (mem_we) mem[mem_addr] = mem_wdata;
          else        mem_rdata = mem[mem_addr];
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       chk;
    logic [7:0] acv;
    logic [4:0] fl;
  } txn_t;

  txn_t       exp_q[$];
  logic [3:0] alu_q[$];

  task automatic exp_f(input logic [7:0] a, input logic [7:0] acv, input logic [4:0] fl);
    exp_q.push_back('{we: 1'b0, addr: a, wdata: 8'h00, chk: 1'b1, acv: acv, fl: fl});
  endtask
  task automatic exp_r(input logic [7:0] a);
    exp_q.push_back('{we: 1'b0, addr: a, wdata: 8'h00, chk: 1'b0, acv: 8'h00, fl: 5'b00000});
  endtask
  task automatic exp_w(input logic [7:0] a, input logic [7:0] d);
    exp_q.push_back('{we: 1'b1, addr: a, wdata: d, chk: 1'b0, acv: 8'h00, fl: 5'b00000});
  endtask

  // Monitor: pops on each completed transaction / each ALU cycle, and checks
  // that request attributes stay stable while mem_req is held.
  logic       prev_req = 1'b0;
  logic [16:0] prev_attr = 17'd0;
  initial begin
    txn_t e;
    logic [3:0] eop;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (mem_req && mem_ack) begin
          if (exp_q.size() == 0) begin
            check("mem_unexpected_txn", 32'(mem_addr), 32'hFFFF);
          end else begin
            e = exp_q.pop_front();
            check("mem_we", 32'(mem_we), 32'(e.we));
            check("mem_addr", 32'(mem_addr), 32'(e.addr));
            if (e.we) begin
              check("mem_wdata", 32'(mem_wdata), 32'(e.wdata));
              n_writes++;
            end
            if (e.chk) begin
              check("ac_at_fetch", 32'(ac), 32'(e.acv));
              check("flags_at_fetch", 32'(flags), 32'(e.fl));
            end
          end
        end
        if (alu_op != 4'd0) begin
          if (alu_q.size() == 0) begin
            check("alu_unexpected_op", 32'(alu_op), 32'h0);
          end else begin
            eop = alu_q.pop_front();
            check("alu_op", 32'(alu_op), 32'(eop));
          end
        end
        if (mem_req && prev_req)
          check("req_stable", 32'({mem_we, mem_addr, mem_wdata}), 32'(prev_attr));
      end
      prev_req  = mem_req && !rst;
      prev_attr = {mem_we, mem_addr, mem_wdata};
    end
  end

  initial begin
    bit seen;
    rst = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'hF0;                                   // HLT, reached after PC wraps
    mem[8'h10] = 8'h20; mem[8'h11] = 8'h80;               // LDA 80
    mem[8'h12] = 8'h30; mem[8'h13] = 8'h81;               // ADD 81
    mem[8'h14] = 8'hE3;                                   // ROL
    mem[8'h15] = 8'h20; mem[8'h16] = 8'h82;               // LDA 82
    mem[8'h17] = 8'hE3;                                   // ROL
    mem[8'h18] = 8'hE0;                                   // SHR
    mem[8'h19] = 8'h70; mem[8'h1A] = 8'h81;               // SUB 81
    mem[8'h1B] = 8'hA0; mem[8'h1C] = 8'h40;               // JZ 40 (not taken)
    mem[8'h1D] = 8'h40; mem[8'h1E] = 8'h83;               // OR 83
    mem[8'h1F] = 8'h50; mem[8'h20] = 8'h84;               // AND 84
    mem[8'h21] = 8'hA0; mem[8'h22] = 8'h40;               // JZ 40 (taken)
    mem[8'h40] = 8'h60;                                   // NOT
    mem[8'h41] = 8'h10; mem[8'h42] = 8'h90;               // STA 90
    mem[8'h43] = 8'h90; mem[8'h44] = 8'h50;               // JN 50 (taken)
    mem[8'h50] = 8'hA8; mem[8'h51] = 8'h60;               // undefined JZ-group code
    mem[8'h52] = 8'hB0; mem[8'h53] = 8'h60;               // JC 60 (taken)
    mem[8'h60] = 8'hE1;                                   // SHL
    mem[8'h61] = 8'hBC; mem[8'h62] = 8'h70;               // JNB 70 (not taken)
    mem[8'h63] = 8'h00;                                   // NOP
    mem[8'h64] = 8'h80; mem[8'h65] = 8'hFF;               // JMP FF
    mem[8'hFF] = 8'hE2;                                   // ROR
    mem[8'h80] = 8'h7F; mem[8'h81] = 8'h01; mem[8'h82] = 8'h80;
    mem[8'h83] = 8'h0F; mem[8'h84] = 8'h00;

    // Expected transactions; flags are {N,Z,V,C,B}
    exp_f(8'h10, 8'h00, 5'b01000); exp_r(8'h11); exp_r(8'h80);
    exp_f(8'h12, 8'h7F, 5'b00000); exp_r(8'h13); exp_r(8'h81);
    exp_f(8'h14, 8'h80, 5'b10100);
    exp_f(8'h15, 8'h00, 5'b01110); exp_r(8'h16); exp_r(8'h82);
    exp_f(8'h17, 8'h80, 5'b10110);
    exp_f(8'h18, 8'h01, 5'b00110);
    exp_f(8'h19, 8'h00, 5'b01110); exp_r(8'h1A); exp_r(8'h81);
    exp_f(8'h1B, 8'hFF, 5'b10011); exp_r(8'h1C);
    exp_f(8'h1D, 8'hFF, 5'b10011); exp_r(8'h1E); exp_r(8'h83);
    exp_f(8'h1F, 8'hFF, 5'b10011); exp_r(8'h20); exp_r(8'h84);
    exp_f(8'h21, 8'h00, 5'b01011); exp_r(8'h22);
    exp_f(8'h40, 8'h00, 5'b01011);
    exp_f(8'h41, 8'hFF, 5'b10011); exp_r(8'h42); exp_w(8'h90, 8'hFF);
    exp_f(8'h43, 8'hFF, 5'b10011); exp_r(8'h44);
    exp_f(8'h50, 8'hFF, 5'b10011); exp_r(8'h51);
    exp_f(8'h52, 8'hFF, 5'b10011); exp_r(8'h53);
    exp_f(8'h60, 8'hFF, 5'b10011);
    exp_f(8'h61, 8'hFE, 5'b10011); exp_r(8'h62);
    exp_f(8'h63, 8'hFE, 5'b10011);
    exp_f(8'h64, 8'hFE, 5'b10011); exp_r(8'h65);
    exp_f(8'hFF, 8'hFE, 5'b10011);
    exp_f(8'h00, 8'hFF, 5'b10001);
    // ADD ROL ROL SHR SUB OR AND NOT SHL ROR
    alu_q = '{4'd1, 4'd7, 4'd7, 4'd10, 4'd2, 4'd3, 4'd4, 4'd5, 4'd9, 4'd8};

    repeat (3) @(negedge clk);
    check("rst_pc", 32'(pc), 32'h10);
    check("rst_ac", 32'(ac), 32'h00);
    check("rst_flags", 32'(flags), 32'(5'b01000));
    check("rst_halted", 32'(halted), 32'h0);
    check("rst_mem_req", 32'(mem_req), 32'h0);
    check("rst_alu_op", 32'(alu_op), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 3000 && !halted; i++) @(negedge clk);
    check("halt_reached", 32'(halted), 32'h1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("halt_no_req", 32'(mem_req), 32'h0);
      check("halt_alu_idle", 32'(alu_op), 32'h0);
    end
    check("final_pc", 32'(pc), 32'h01);
    check("final_ac", 32'(ac), 32'hFF);
    check("final_flags", 32'(flags), 32'(5'b10001));
    check("exp_queue_drained", 32'(exp_q.size()), 32'd0);
    check("alu_queue_drained", 32'(alu_q.size()), 32'd0);
    check("write_count", 32'(n_writes), 32'd1);
    check("stored_value", 32'(mem[8'h90]), 32'hFF);

    // Reset arriving while a fetch is pending
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      #2;
      seen = mem_req;
    end
    check("rst_fetch_req_seen", 32'(seen), 32'h1);
    rst = 1'b1;
    #1;
    check("rst_mid_mem_req", 32'(mem_req), 32'h0);
    check("rst_mid_pc", 32'(pc), 32'h10);
    check("rst_mid_halted", 32'(halted), 32'h0);
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
